// File: rtl/booth_dot_accumulator.sv
// booth_dot_accumulator
//   Back end for the radix-4 Booth multiplier. Sums a job of LEN signed
//   products into a wider signed accumulator and presents the sum, the
//   product count and a sticky overflow flag on a valid/ready port.
//   The multiplier is held off (o_in_ready low) outside an active job.
//
//   Build option: define BOOTH_ACC_SAT_EN to clamp the accumulator at the
//   signed limits on overflow. Without it the accumulator wraps modulo
//   2**ACC_W. The overflow flag is set in both builds.
//
//   ACC_W must be at least PROD_W+1 so a single product always fits.
module booth_dot_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [LEN_W-1:0]         i_len,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic signed [PROD_W-1:0] i_in_product,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic signed [ACC_W-1:0]  o_out_sum,
    output logic [LEN_W-1:0]         o_out_count,
    output logic                     o_overflow,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]          r_count;
    logic [LEN_W-1:0]          r_len_q;
    logic                      r_overflow;
    logic                      r_out_valid;
    logic                      r_busy;

    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_raw_sum;
    logic signed [ACC_W-1:0]   w_next_acc;
    logic                      w_add_ovf;
    logic                      w_xfer;
    logic                      w_last;

    // Sign-extend the product to accumulator width.
    assign w_prod_ext = {{(ACC_W-PROD_W){i_in_product[PROD_W-1]}}, i_in_product};
    assign w_raw_sum  = r_acc + w_prod_ext;

    // Two's complement overflow: like-signed operands, result sign flipped.
    assign w_add_ovf = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                       (w_raw_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
    // On overflow both operands share the accumulator's sign, so that sign
    // picks the rail to clamp to.
    assign w_next_acc = w_add_ovf ? (r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_raw_sum;
`else
    // Plain modulo-2**ACC_W wrap; the limits are unused in this build.
    assign w_next_acc = w_raw_sum;
    logic w_unused_limits;
    assign w_unused_limits = ^{ACC_MAX, ACC_MIN};
`endif

    // A product is consumed only while a job is accumulating.
    assign w_xfer = i_in_valid && (r_state == S_ACCUM);
    assign w_last = (r_count == (r_len_q - LEN_W'(1)));

    // Job control FSM with accumulator datapath and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_len_q     <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        if (i_len != '0) begin
                            r_len_q <= i_len;
                            r_state <= S_ACCUM;
                        end else begin
                            // Empty job: report a zero result straight away.
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        r_acc      <= w_next_acc;
                        r_count    <= r_count + LEN_W'(1);
                        r_overflow <= r_overflow | w_add_ovf;
                        if (w_last) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Start requests here are dropped, even on the leaving cycle.
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_ACCUM);
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_acc;
    assign o_out_count = r_count;
    assign o_overflow  = r_overflow;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Scoreboard bench for booth_dot_accumulator (ACC_W=17 so overflow is reachable).
module tb_booth_dot_accumulator;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 17;
    localparam int LEN_W  = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     i_start = 1'b0;
    logic [LEN_W-1:0]         i_len = '0;
    logic                     i_in_valid = 1'b0;
    logic                     o_in_ready;
    logic signed [PROD_W-1:0] i_in_product = '0;
    logic                     o_out_valid;
    logic                     i_out_ready = 1'b0;
    logic signed [ACC_W-1:0]  o_out_sum;
    logic [LEN_W-1:0]         o_out_count;
    logic                     o_overflow;
    logic                     o_busy;

    typedef struct {
        int    sum;
        int    cnt;
        int    ovf;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;

    booth_dot_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_product (i_in_product),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_sum    (o_out_sum),
        .o_out_count  (o_out_count),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: compare every accepted result against the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && o_out_valid && i_out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, "_sum"},   longint'(o_out_sum), e.sum);
                    chk({e.name, "_count"}, o_out_count, e.cnt);
                    chk({e.name, "_ovf"},   o_overflow, e.ovf);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input int len);
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic send(input int v);
        i_in_valid   = 1'b1;
        i_in_product = PROD_W'(v);
        tick(1);
        i_in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, then accept it; optionally raise start on that cycle.
    task automatic accept(input bit with_start);
        int n;
        n = 0;
        while (!o_out_valid && n < 20) begin
            tick(1);
            n++;
        end
        if (!o_out_valid) chk("out_valid_timeout", 0, 1);
        i_out_ready = 1'b1;
        if (with_start) begin
            i_start = 1'b1;
            i_len   = LEN_W'(4);
        end
        tick(1);
        i_out_ready = 1'b0;
        i_start     = 1'b0;
    endtask

    initial begin
        // Power-on reset.
        rst = 1'b1;
        tick(2);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_in_ready",  o_in_ready, 0);
        chk("rst_sum",       longint'(o_out_sum), 0);
        chk("rst_busy",      o_busy, 0);
        rst = 1'b0;
        tick(1);

        // T1: reset mid-job after two products aborts with no output.
        start_job(5);
        send(11);
        send(-4);
        chk("t1_in_ready_mid", o_in_ready, 1);
        chk("t1_count_mid",    o_out_count, 2);
        chk("t1_sum_mid",      longint'(o_out_sum), 7);
        rst = 1'b1;
        #1;
        chk("t1_out_valid", o_out_valid, 0);
        chk("t1_in_ready",  o_in_ready, 0);
        chk("t1_sum",       longint'(o_out_sum), 0);
        chk("t1_count",     o_out_count, 0);
        chk("t1_ovf",       o_overflow, 0);
        chk("t1_busy",      o_busy, 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // T2: len=3, back-to-back 5, -3, 100 -> 102.
        q.push_back('{102, 3, 0, "t2"});
        start_job(3);
        send(5);
        send(-3);
        chk("t2_not_yet_valid", o_out_valid, 0);
        send(100);
        chk("t2_valid_latency", o_out_valid, 1);
        chk("t2_in_ready_hold", o_in_ready, 0);
        accept(1'b0);
        chk("t2_idle_busy", o_busy, 0);

        // T3: zero-length job; in_valid pulses are ignored.
        q.push_back('{0, 0, 0, "t3"});
        start_job(0);
        chk("t3_valid_next", o_out_valid, 1);
        chk("t3_in_ready",   o_in_ready, 0);
        send(55);
        send(-77);
        chk("t3_sum_stable", longint'(o_out_sum), 0);
        accept(1'b0);
        send(123);
        chk("t3_idle_sum", longint'(o_out_sum), 0);

        // T4: gapped inputs and held result under backpressure.
        q.push_back('{-2, 2, 0, "t4"});
        start_job(2);
        tick(2);
        send(7);
        tick(3);
        chk("t4_gap_sum", longint'(o_out_sum), 7);
        send(-9);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                i_start = 1'b1;
                i_len   = LEN_W'(7);
            end
            chk("t4_hold_sum",      longint'(o_out_sum), -2);
            chk("t4_hold_valid",    o_out_valid, 1);
            chk("t4_hold_in_ready", o_in_ready, 0);
            tick(1);
            i_start = 1'b0;
        end
        chk("t4_count_after_start", o_out_count, 2);
        chk("t4_busy_hold", o_busy, 1);
        accept(1'b1);
        chk("t4_leave_busy", o_busy, 0);
        tick(1);
        chk("t4_start_dropped", o_in_ready, 0);

        // T5: positive overflow.
`ifdef BOOTH_ACC_SAT_EN
        q.push_back('{65535, 3, 1, "t5"});
`else
        q.push_back('{-32771, 3, 1, "t5"});
`endif
        start_job(3);
        send(32767);
        send(32767);
        chk("t5_no_ovf_yet", o_overflow, 0);
        send(32767);
        accept(1'b0);

        // T6: negative overflow, then a clean job clears the flag.
`ifdef BOOTH_ACC_SAT_EN
        q.push_back('{-65536, 3, 1, "t6"});
`else
        q.push_back('{32768, 3, 1, "t6"});
`endif
        start_job(3);
        send(-32768);
        send(-32768);
        send(-32768);
        accept(1'b0);
        q.push_back('{1, 1, 0, "t6b"});
        start_job(1);
        send(1);
        accept(1'b0);

        tick(3);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
